// File: rtl/ti_pkg.sv
// rtl/ti_pkg.sv - shared defaults, FSM states and share type for the TI share recombiner
package ti_pkg;

  localparam int TI_WIDTH   = 4;
  localparam int TI_NSHARES = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  typedef logic [TI_WIDTH-1:0] share_t;

endpackage

// File: rtl/ti_xor_acc.sv
// rtl/ti_xor_acc.sv - share XOR accumulator and share counter; holds partial XORs only
module ti_xor_acc #(
  parameter int WIDTH   = 4,
  parameter int NSHARES = 4,
  parameter int CNTW    = $clog2(NSHARES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_xen,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_acc_xor,
  output logic [CNTW-1:0]  o_cnt
);

  logic [WIDTH-1:0] r_acc;
  logic [CNTW-1:0]  r_cnt;

  // clear wins so the partial XOR never survives past the end of a value
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_acc <= i_din;
      r_cnt <= CNTW'(1);
    end else if (i_xen) begin
      r_acc <= r_acc ^ i_din;
      r_cnt <= r_cnt + CNTW'(1);
    end
  end

  assign o_acc_xor = r_acc ^ i_din;
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/ti_share_recombiner.sv
// rtl/ti_share_recombiner.sv - serial TI share recombiner: XORs NSHARES shares into one unmasked value
module ti_share_recombiner
  import ti_pkg::*;
#(
  parameter  int WIDTH   = TI_WIDTH,
  parameter  int NSHARES = TI_NSHARES,
  localparam int CNTW    = $clog2(NSHARES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_share,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err,
  output logic [CNTW-1:0]  share_cnt
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_err;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_last_share;
  logic             w_clr;
  logic             w_load;
  logic             w_xen;
  logic             w_out_load;
  logic             w_err_set;
  logic [WIDTH-1:0] w_acc_xor;
  logic [CNTW-1:0]  w_cnt;

  ti_xor_acc #(
    .WIDTH   (WIDTH),
    .NSHARES (NSHARES),
    .CNTW    (CNTW)
  ) u_acc (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_load    (w_load),
    .i_xen     (w_xen),
    .i_din     (in_share),
    .o_acc_xor (w_acc_xor),
    .o_cnt     (w_cnt)
  );

  assign w_in_ready   = !rst && (r_state != HOLD);
  assign w_accept     = in_valid && w_in_ready;
  assign w_last_share = (w_cnt == CNTW'(NSHARES - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_load      = 1'b0;
    w_xen       = 1'b0;
    w_out_load  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      IDLE: begin
        // in_last on the first share is always early since NSHARES >= 2
        if (w_accept) begin
          if (in_last) begin
            w_err_set = 1'b1;
            w_clr     = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (w_accept) begin
          if (w_last_share) begin
            w_out_load  = 1'b1;
            w_clr       = 1'b1;
            w_err_set   = !in_last;
            w_state_nxt = HOLD;
          end else if (in_last) begin
            w_err_set   = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_xen = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_out_data <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_out_load) begin
        r_out_data <= w_acc_xor;
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_data  = r_out_data;
  assign out_valid = (r_state == HOLD);
  assign err       = r_err;
  assign share_cnt = w_cnt;

endmodule

// File: tb/tb_ti_share_recombiner.sv
// tb/tb_ti_share_recombiner.sv - directed vector bench for ti_share_recombiner
module tb_ti_share_recombiner;
  import ti_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  share_t     in_share;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  share_t     out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err;
  logic [1:0] share_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  ti_share_recombiner #(.WIDTH(4), .NSHARES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_share  (in_share),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .share_cnt (share_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] shares;
    logic [3:0]  lasts;
    logic [3:0]  exp_data;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic send_share(input logic [3:0] s, input logic l);
    int n;
    n = 0;
    in_share = s;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_value(input logic [15:0] sh, input logic [3:0] ls);
    for (int i = 0; i < 4; i++) send_share(sh[15-4*i -: 4], ls[3-i]);
  endtask

  initial begin
    rst = 1'b1; in_share = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;

    vecs[0] = '{16'h3590, 4'b0001, 4'hF};
    vecs[1] = '{16'h1248, 4'b0001, 4'hF};
    vecs[2] = '{16'hAA17, 4'b0001, 4'h6};
    vecs[3] = '{16'h0000, 4'b0001, 4'h0};
    vecs[4] = '{16'hFFFF, 4'b0001, 4'h0};
    vecs[5] = '{16'h8422, 4'b0001, 4'hC};

    step();
    do_reset();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data",  {28'd0, out_data},  32'd0);
    check("rst_err",       {31'd0, err},       32'd0);
    check("rst_share_cnt", {30'd0, share_cnt}, 32'd0);

    // table: clean values, out_ready held high
    for (int v = 0; v < 6; v++) begin
      send_value(vecs[v].shares, vecs[v].lasts);
      check($sformatf("vec%0d_valid", v), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_data", v),  {28'd0, out_data},  {28'd0, vecs[v].exp_data});
      check($sformatf("vec%0d_err", v),   {31'd0, err},       32'd0);
      step();
      check($sformatf("vec%0d_one_cycle", v), {31'd0, out_valid}, 32'd0);
    end

    // backpressure with input hammering while held
    out_ready = 1'b0;
    send_value(16'hAA17, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_share = 4'(c + 3);
      #1;
      check("bp_in_ready", {31'd0, in_ready},  32'd0);
      check("bp_valid",    {31'd0, out_valid}, 32'd1);
      check("bp_data",     {28'd0, out_data},  32'h6);
      step();
    end
    out_ready = 1'b1;
    in_share  = 4'h5;
    step();
    in_valid = 1'b0;
    check("bp_release_valid", {31'd0, out_valid}, 32'd0);
    check("bp_no_bypass_cnt", {30'd0, share_cnt}, 32'd0);
    check("bp_release_ready", {31'd0, in_ready},  32'd1);
    send_value(16'h3590, 4'b0001);
    check("bp_next_data", {28'd0, out_data}, 32'hF);
    step();

    // gapped input with share_cnt trace
    check("gap_cnt0", {30'd0, share_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      send_share(4'(1 << i), i == 3);
      check($sformatf("gap_cnt_after%0d", i), {30'd0, share_cnt}, (i == 3) ? 32'd0 : 32'(i + 1));
      if (i == 3) check("gap_data", {28'd0, out_data}, 32'hF);
      step();
    end

    // early in_last on share 2
    send_share(4'h5, 1'b0);
    send_share(4'hC, 1'b1);
    check("early_err", {31'd0, err}, 32'd1);
    check("early_cnt", {30'd0, share_cnt}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("early_no_valid", {31'd0, out_valid}, 32'd0);
      step();
    end
    send_value(16'h3590, 4'b0001);
    check("early_next_data", {28'd0, out_data}, 32'hF);
    check("early_err_sticky", {31'd0, err}, 32'd1);
    step();

    // missing in_last
    do_reset();
    send_value(16'h1110, 4'b0000);
    check("nolast_valid", {31'd0, out_valid}, 32'd1);
    check("nolast_data",  {28'd0, out_data},  32'h1);
    check("nolast_err",   {31'd0, err},       32'd1);
    step();

    // reset mid-accumulation, share offered during rst
    send_share(4'h7, 1'b0);
    send_share(4'h3, 1'b0);
    in_valid = 1'b1; in_share = 4'h9;
    do_reset();
    in_valid = 1'b0;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_cnt",   {30'd0, share_cnt}, 32'd0);
    check("midrst_err",   {31'd0, err},       32'd0);
    send_value(16'h3590, 4'b0001);
    check("midrst_fresh", {28'd0, out_data}, 32'hF);
    step();

    // reset while holding an unaccepted value
    out_ready = 1'b0;
    send_value(16'h1248, 4'b0001);
    check("holdrst_pre", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    do_reset();
    check("holdrst_valid", {31'd0, out_valid}, 32'd0);
    check("holdrst_data",  {28'd0, out_data},  32'd0);
    check("holdrst_cnt",   {30'd0, share_cnt}, 32'd0);
    check("holdrst_ready", {31'd0, in_ready},  32'd1);
    send_value(16'h8422, 4'b0001);
    check("holdrst_fresh", {28'd0, out_data}, 32'hC);
    check("holdrst_err",   {31'd0, err},      32'd0);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
